// File: rtl/sdram_line_cache_ctrl.sv
// Direct-mapped write-back byte cache in front of the SDRAM burst port.
// Line fills and dirty spills are whole 8 x 16-bit bursts; the CPU waits on cpu_ack.
module sdram_line_cache_ctrl #(
    parameter int ADDR_WIDTH = 24,
    parameter int INDEX_BITS = 5
) (
    input  logic                  clk1x,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [7:0]            cpu_wdata,
    output logic [7:0]            cpu_rdata,
    output logic                  cpu_ack,
    output logic                  sdram_rd,
    output logic                  sdram_wr,
    output logic [ADDR_WIDTH-1:0] sdram_addr,
    output logic [15:0]           sdram_wdata,
    input  logic [15:0]           sdram_rdata,
    input  logic                  sdram_ready,
    input  logic [2:0]            sdram_burst_offset
);

    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 4;
    localparam int LINES    = 2**INDEX_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_DONE,
        S_SPILL_REQ,
        S_SPILL,
        S_FILL_REQ,
        S_FILL
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    we_q;
    logic [7:0]              wdata_q;
    logic [LINES-1:0]        valid_q, valid_d;
    logic [LINES-1:0]        dirty_q, dirty_d;
    logic [7:0]              rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0]   sdram_addr_q, sdram_addr_d;

    logic [TAG_BITS-1:0]     tag_mem [LINES];

    logic [TAG_BITS-1:0]     tag_l;
    logic [INDEX_BITS-1:0]   idx_l;
    logic [2:0]              word_l;
    logic                    byte_l;
    logic [INDEX_BITS+2:0]   cpu_ptr;
    logic [INDEX_BITS+2:0]   burst_ptr;
    logic                    hit;
    logic                    byte_we;
    logic                    fill_we;
    logic                    tag_we;
    logic [7:0]              lane_rd [2];
    logic [7:0]              lane_sp [2];

    assign tag_l     = addr_q[ADDR_WIDTH-1 -: TAG_BITS];
    assign idx_l     = addr_q[INDEX_BITS+3:4];
    assign word_l    = addr_q[3:1];
    assign byte_l    = addr_q[0];
    assign cpu_ptr   = {idx_l, word_l};
    assign burst_ptr = {idx_l, sdram_burst_offset};
    assign hit       = valid_q[idx_l] && (tag_mem[idx_l] == tag_l);

    // Line storage split into low/high byte lanes so a CPU write touches one byte only.
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic [7:0] lane_mem [LINES*8];

        always_ff @(posedge clk1x) begin
            if (fill_we) begin
                lane_mem[burst_ptr] <= sdram_rdata[gi*8 +: 8];
            end else if (byte_we && (byte_l == 1'(gi))) begin
                lane_mem[cpu_ptr] <= wdata_q;
            end
        end

        assign lane_rd[gi] = lane_mem[cpu_ptr];
        assign lane_sp[gi] = lane_mem[burst_ptr];
    end

    always_ff @(posedge clk1x) begin
        if (tag_we) begin
            tag_mem[idx_l] <= tag_l;
        end
    end

    always_ff @(posedge clk1x) begin
        if (state_q == S_IDLE && cpu_req) begin
            addr_q  <= cpu_addr;
            we_q    <= cpu_we;
            wdata_q <= cpu_wdata;
        end
    end

    always_ff @(posedge clk1x) begin
        if (reset) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            rdata_q      <= '0;
            sdram_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            rdata_q      <= rdata_d;
            sdram_addr_q <= sdram_addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        rdata_d      = rdata_q;
        sdram_addr_d = sdram_addr_q;
        byte_we      = 1'b0;
        fill_we      = 1'b0;
        tag_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    if (we_q) begin
                        byte_we        = 1'b1;
                        dirty_d[idx_l] = 1'b1;
                    end else begin
                        rdata_d = byte_l ? lane_rd[1] : lane_rd[0];
                    end
                    state_d = S_DONE;
                end else if (valid_q[idx_l] && dirty_q[idx_l]) begin
                    sdram_addr_d = {tag_mem[idx_l], idx_l, 4'h0};
                    state_d      = S_SPILL_REQ;
                end else begin
                    sdram_addr_d = {tag_l, idx_l, 4'h0};
                    state_d      = S_FILL_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_SPILL_REQ: begin
                state_d = S_SPILL;
            end
            S_SPILL: begin
                if (sdram_ready && sdram_burst_offset == 3'd7) begin
                    dirty_d[idx_l] = 1'b0;
                    sdram_addr_d   = {tag_l, idx_l, 4'h0};
                    state_d        = S_FILL_REQ;
                end
            end
            S_FILL_REQ: begin
                // Line is inconsistent until the last fill word lands.
                valid_d[idx_l] = 1'b0;
                state_d        = S_FILL;
            end
            S_FILL: begin
                if (sdram_ready) begin
                    fill_we = 1'b1;
                    if (sdram_burst_offset == 3'd7) begin
                        valid_d[idx_l] = 1'b1;
                        dirty_d[idx_l] = 1'b0;
                        tag_we         = 1'b1;
                        state_d        = S_LOOKUP;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cpu_rdata   = rdata_q;
    assign cpu_ack     = (state_q == S_DONE);
    assign sdram_rd    = (state_q == S_FILL_REQ);
    assign sdram_wr    = (state_q == S_SPILL_REQ);
    assign sdram_addr  = sdram_addr_q;
    assign sdram_wdata = {lane_sp[1], lane_sp[0]};

endmodule

// File: tb/tb_sdram_line_cache_ctrl.sv
// Bench for sdram_line_cache_ctrl: vector table plus an SDRAM burst model with random stalls;
// read data is checked against a flat byte-memory scoreboard.
module tb_sdram_line_cache_ctrl;

    logic        clk1x = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [23:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        sdram_rd;
    logic        sdram_wr;
    logic [23:0] sdram_addr;
    logic [15:0] sdram_wdata;
    logic [15:0] sdram_rdata;
    logic        sdram_ready;
    logic [2:0]  sdram_burst_offset;

    always #5 clk1x = ~clk1x;

    sdram_line_cache_ctrl dut (
        .clk1x              (clk1x),
        .reset              (reset),
        .cpu_req            (cpu_req),
        .cpu_we             (cpu_we),
        .cpu_addr           (cpu_addr),
        .cpu_wdata          (cpu_wdata),
        .cpu_rdata          (cpu_rdata),
        .cpu_ack            (cpu_ack),
        .sdram_rd           (sdram_rd),
        .sdram_wr           (sdram_wr),
        .sdram_addr         (sdram_addr),
        .sdram_wdata        (sdram_wdata),
        .sdram_rdata        (sdram_rdata),
        .sdram_ready        (sdram_ready),
        .sdram_burst_offset (sdram_burst_offset)
    );

    typedef struct {
        bit          we;
        logic [23:0] addr;
        logic [7:0]  wdata;
        int          n_rd;     // -1: traffic not checked
        int          n_wr;
        logic [23:0] rd_addr;
        logic [23:0] wr_addr;
        int          lat;      // 0: latency not checked
    } vec_t;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Initial SDRAM contents; word address 0x91A (bytes 0x1234/0x1235) holds 0xBEEF.
    function automatic logic [15:0] init_word(input logic [13:0] w);
        if (w == 14'h091A) return 16'hBEEF;
        return (16'(w) * 16'h02B7) ^ 16'h5A3C;
    endfunction

    // SDRAM backing store (only the model's always block writes it)
    logic [15:0] sdram_mem [16384];
    bit          sdram_wv  [16384];
    logic [13:0] base_w;
    logic [2:0]  model_off;
    bit          burst_active;
    bit          burst_is_rd;

    function automatic logic [15:0] mem_rd(input logic [13:0] w);
        return sdram_wv[w] ? sdram_mem[w] : init_word(w);
    endfunction

    always @(posedge clk1x) begin
        if (reset) begin
            burst_active       <= 1'b0;
            sdram_ready        <= 1'b0;
            sdram_burst_offset <= '0;
            sdram_rdata        <= '0;
        end else if (!burst_active) begin
            sdram_ready <= 1'b0;
            if (sdram_rd || sdram_wr) begin
                burst_active <= 1'b1;
                burst_is_rd  <= sdram_rd;
                base_w       <= sdram_addr[14:1];
                model_off    <= 3'd0;
            end
        end else begin
            if (sdram_ready && !burst_is_rd) begin
                sdram_mem[base_w + 14'(sdram_burst_offset)] <= sdram_wdata;
                sdram_wv[base_w + 14'(sdram_burst_offset)]  <= 1'b1;
            end
            if (sdram_ready && sdram_burst_offset == 3'd7) begin
                burst_active <= 1'b0;
                sdram_ready  <= 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                sdram_ready <= 1'b0;
            end else begin
                sdram_ready        <= 1'b1;
                sdram_burst_offset <= model_off;
                sdram_rdata        <= mem_rd(base_w + 14'(model_off));
                model_off          <= model_off + 3'd1;
            end
        end
    end

    // Golden flat byte memory as the CPU should see it
    logic [7:0]  gold_b  [32768];
    bit          gold_wv [32768];
    logic [7:0]  sb_q [$];

    function automatic logic [7:0] gold_read(input logic [23:0] a);
        logic [15:0] w;
        if (gold_wv[a[14:0]]) return gold_b[a[14:0]];
        w = init_word(a[14:1]);
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input bit we, input logic [23:0] addr, input logic [7:0] wd,
                                input int n_rd, input int n_wr, input logic [23:0] ra,
                                input logic [23:0] wa, input int lat);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wd; v.n_rd = n_rd; v.n_wr = n_wr;
        v.rd_addr = ra; v.wr_addr = wa; v.lat = lat;
        return v;
    endfunction

    task automatic do_access(input vec_t v, input int id);
        int          cyc;
        int          n_rd;
        int          n_wr;
        int          n_both;
        logic [23:0] a_rd;
        logic [23:0] a_wr;
        bit          acked;
        logic [7:0]  expb;
        @(negedge clk1x);
        cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        if (v.we) begin
            gold_b[v.addr[14:0]]  = v.wdata;
            gold_wv[v.addr[14:0]] = 1'b1;
        end else begin
            sb_q.push_back(gold_read(v.addr));
        end
        cyc = 0; n_rd = 0; n_wr = 0; n_both = 0; a_rd = '0; a_wr = '0; acked = 1'b0;
        while (!acked && cyc < 400) begin
            @(negedge clk1x);
            cyc++;
            if (sdram_rd) begin n_rd++; a_rd = sdram_addr; end
            if (sdram_wr) begin n_wr++; a_wr = sdram_addr; end
            if (sdram_rd && sdram_wr) n_both++;
            if (cpu_ack) begin acked = 1'b1; cpu_req = 1'b0; end
        end
        chk($sformatf("ack_seen[%0d]", id), 32'(acked), 32'd1);
        chk($sformatf("rd_wr_overlap[%0d]", id), 32'(n_both), 32'd0);
        if (!v.we) begin
            expb = sb_q.pop_front();
            if (acked) chk($sformatf("rdata[%0d]", id), 32'(cpu_rdata), 32'(expb));
        end
        if (v.n_rd >= 0) begin
            chk($sformatf("sdram_rd_count[%0d]", id), 32'(n_rd), 32'(v.n_rd));
            chk($sformatf("sdram_wr_count[%0d]", id), 32'(n_wr), 32'(v.n_wr));
            if (v.n_rd > 0) chk($sformatf("fill_addr[%0d]", id), 32'(a_rd), 32'(v.rd_addr));
            if (v.n_wr > 0) chk($sformatf("spill_addr[%0d]", id), 32'(a_wr), 32'(v.wr_addr));
        end
        if (v.lat > 0) chk($sformatf("latency[%0d]", id), 32'(cyc), 32'(v.lat));
        @(negedge clk1x);
        chk($sformatf("ack_one_cycle[%0d]", id), 32'(cpu_ack), 32'd0);
        cpu_req = 1'b0;
        $display("txn %0d we=%0b addr=%h wdata=%h rdata=%h cycles=%0d rd=%0d wr=%0d",
                 id, v.we, v.addr, v.wdata, cpu_rdata, cyc, n_rd, n_wr);
    endtask

    vec_t vecs [11];

    initial begin
        int          cyc;
        int          n_rd;
        int          n_wr;
        int          n_ack;
        logic [15:0] w;
        logic [23:0] ra;

        vecs[0]  = mk(0, 24'h001234, 8'h00, 1, 0, 24'h001230, 24'h0, 0);
        vecs[1]  = mk(0, 24'h001235, 8'h00, 0, 0, 24'h0, 24'h0, 2);
        vecs[2]  = mk(1, 24'h001236, 8'hA5, 0, 0, 24'h0, 24'h0, 2);
        vecs[3]  = mk(0, 24'h001236, 8'h00, 0, 0, 24'h0, 24'h0, 2);
        vecs[4]  = mk(0, 24'h003230, 8'h00, 1, 1, 24'h003230, 24'h001230, 0);
        vecs[5]  = mk(0, 24'h001236, 8'h00, 1, 0, 24'h001230, 24'h0, 0);
        vecs[6]  = mk(0, 24'h003230, 8'h00, 1, 0, 24'h003230, 24'h0, 0);
        vecs[7]  = mk(1, 24'h000010, 8'h5A, 1, 0, 24'h000010, 24'h0, 0);
        vecs[8]  = mk(0, 24'h000011, 8'h00, 0, 0, 24'h0, 24'h0, 2);
        vecs[9]  = mk(0, 24'h002010, 8'h00, 1, 1, 24'h002010, 24'h000010, 0);
        vecs[10] = mk(0, 24'h000010, 8'h00, 1, 0, 24'h000010, 24'h0, 0);

        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(negedge clk1x);
        reset = 1'b0;
        @(negedge clk1x);
        chk("reset_ack", 32'(cpu_ack), 32'd0);
        chk("reset_sdram_rd", 32'(sdram_rd), 32'd0);
        chk("reset_sdram_wr", 32'(sdram_wr), 32'd0);
        chk("reset_sdram_addr", 32'(sdram_addr), 32'd0);
        chk("reset_rdata", 32'(cpu_rdata), 32'd0);

        for (int i = 0; i <= 5; i++) begin
            do_access(vecs[i], i);
            if (i == 4) begin
                w = mem_rd(14'h091B);
                chk("spill_word3_low", 32'(w[7:0]), 32'hA5);
            end
        end

        // Reset while the fill of 0x003230 is at offset 4
        @(negedge clk1x);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h003230;
        cyc = 0;
        while (!(sdram_ready && sdram_burst_offset == 3'd4 && dut.state_q != dut.S_IDLE)
               && cyc < 400) begin
            @(negedge clk1x);
            cyc++;
        end
        chk("reach_fill_offset4", 32'(cyc < 400), 32'd1);
        reset = 1'b1; cpu_req = 1'b0;
        n_rd = 0; n_wr = 0; n_ack = 0; ra = '1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk1x);
            if (i == 0) ra = sdram_addr;
            if (i == 1) reset = 1'b0;
            if (sdram_rd) n_rd++;
            if (sdram_wr) n_wr++;
            if (cpu_ack) n_ack++;
        end
        chk("midfill_reset_addr", 32'(ra), 32'd0);
        chk("midfill_reset_rd", 32'(n_rd), 32'd0);
        chk("midfill_reset_wr", 32'(n_wr), 32'd0);
        chk("midfill_reset_ack", 32'(n_ack), 32'd0);
        $display("txn reset-mid-fill addr=003230 cycles=%0d", cyc);

        for (int i = 6; i <= 10; i++) begin
            do_access(vecs[i], i);
            if (i == 9) begin
                w = mem_rd(14'h0008);
                chk("spill_5A_low", 32'(w[7:0]), 32'h5A);
            end
        end

        // Random traffic across a few conflicting tags on the low lines
        for (int i = 0; i < 60; i++) begin
            vec_t v;
            logic [23:0] a;
            a = (24'($urandom_range(0, 3)) << 9) | (24'($urandom_range(0, 3)) << 4)
                | 24'($urandom_range(0, 15));
            v = mk(bit'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)),
                   -1, 0, 24'h0, 24'h0, 0);
            do_access(v, 100 + i);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
